// File: rtl/systolic_input_feeder_if.sv
// Handshake and skewed-output bundle between the activation source, the feeder and the array left edge.
interface systolic_input_feeder_if #(
    parameter int unsigned ROWS       = 2,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [ROWS*DATA_WIDTH-1:0] in_data;
    logic                       in_first;
    logic                       in_last;
    logic                       in_valid;
    logic                       in_ready;
    logic                       hold;
    logic [ROWS*DATA_WIDTH-1:0] out_input;
    logic [ROWS-1:0]            out_valid;
    logic [ROWS-1:0]            out_switch;
    logic                       tile_done;
    logic                       busy;

    modport master (
        output in_data, in_first, in_last, in_valid, hold,
        input  in_ready, out_input, out_valid, out_switch, tile_done, busy
    );

    modport slave (
        input  in_data, in_first, in_last, in_valid, hold,
        output in_ready, out_input, out_valid, out_switch, tile_done, busy
    );
endinterface

// File: rtl/systolic_input_feeder.sv
// Activation feeder: vector FIFO followed by a per-row skew so row r sees its element r cycles after row 0.
module systolic_input_feeder #(
    parameter int unsigned ROWS       = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input logic                    clk,
    input logic                    rst,
    systolic_input_feeder_if.slave bus
);
    localparam int unsigned VW = ROWS * DATA_WIDTH;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [VW-1:0] data;
        logic          first;
        logic          last;
    } entry_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  valid;
        logic                  first;
    } lane_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ready_en;
    logic            push;
    logic            pop;
    entry_t          head;
    logic [ROWS-1:0] last_sr;
    logic [ROWS-1:0] row_busy;

    // ready_en keeps in_ready low until the first edge after reset release
    assign bus.in_ready = ready_en && (count < CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (count != '0) && !bus.hold;
    assign head         = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{data: bus.in_data, first: bus.in_first, last: bus.in_last};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Last-of-tile marker travels alongside the vector to the bottom row
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_sr <= '0;
        end else begin
            last_sr[0] <= pop && head.last;
            for (int k = 1; k < int'(ROWS); k++) begin
                last_sr[k] <= last_sr[k-1];
            end
        end
    end

    assign bus.tile_done = last_sr[ROWS-1];

    for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
        lane_t chain [r+1];
        logic  any_valid;

        // chain[0] is this lane of stage 0; bubbles load all-zero so the PE holds
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k <= r; k++) chain[k] <= '0;
            end else begin
                chain[0] <= pop ? '{data:  head.data[r*DATA_WIDTH +: DATA_WIDTH],
                                    valid: 1'b1,
                                    first: head.first} : '0;
                for (int k = 1; k <= r; k++) chain[k] <= chain[k-1];
            end
        end

        always_comb begin
            any_valid = 1'b0;
            for (int k = 0; k <= r; k++) any_valid = any_valid | chain[k].valid;
        end

        assign row_busy[r]                                = any_valid;
        assign bus.out_input[r*DATA_WIDTH +: DATA_WIDTH] = chain[r].data;
        assign bus.out_valid[r]                           = chain[r].valid;
        assign bus.out_switch[r]                          = chain[r].first;
    end

    assign bus.busy = (count != '0) || (|row_busy);

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Scoreboard bench for systolic_input_feeder: per-row expected queues filled on accept, drained on out_valid.
module tb_systolic_input_feeder;
    localparam int unsigned ROWS  = 2;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          first;
        logic          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   td_seen = 0;
    exp_t q0[$];
    exp_t q1[$];

    systolic_input_feeder_if #(.ROWS(ROWS), .DATA_WIDTH(DW)) bus ();

    systolic_input_feeder #(.ROWS(ROWS), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: every valid row output must match the head of that row's queue
    always @(negedge clk) if (rst) begin
        exp_t e;
        logic td_exp;
        td_exp = 1'b0;
        if (bus.tile_done) td_seen++;
        if (bus.out_valid[0]) begin
            if (q0.size() == 0) check("row0_unexpected", 64'd1, 64'd0);
            else begin
                e = q0.pop_front();
                check("row0_data", 64'(bus.out_input[DW-1:0]), 64'(e.data));
                check("row0_switch", 64'(bus.out_switch[0]), 64'(e.first));
            end
        end else begin
            check("row0_idle_switch", 64'(bus.out_switch[0]), 64'd0);
            check("row0_idle_data", 64'(bus.out_input[DW-1:0]), 64'd0);
        end
        if (bus.out_valid[1]) begin
            if (q1.size() == 0) check("row1_unexpected", 64'd1, 64'd0);
            else begin
                e = q1.pop_front();
                td_exp = e.last;
                check("row1_data", 64'(bus.out_input[2*DW-1:DW]), 64'(e.data));
                check("row1_switch", 64'(bus.out_switch[1]), 64'(e.first));
            end
        end else begin
            check("row1_idle_switch", 64'(bus.out_switch[1]), 64'd0);
            check("row1_idle_data", 64'(bus.out_input[2*DW-1:DW]), 64'd0);
        end
        check("tile_done", 64'(bus.tile_done), 64'(td_exp));
    end

    // Offer one vector from a negedge; returns on the negedge after it is accepted
    task automatic push_vec(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input logic f, input logic l, output int tries);
        logic acc;
        acc   = 1'b0;
        tries = 0;
        bus.in_data  = {d1, d0};
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            #1;
            acc = bus.in_ready;
            tries++;
            if (acc) begin
                q0.push_back('{d0, f, l});
                q1.push_back('{d1, f, l});
            end
            @(negedge clk);
        end
        if (!acc) check("push_timeout", 64'd1, 64'd0);
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int t = 0; t < 100 && (bus.busy || q0.size() != 0 || q1.size() != 0); t++)
            @(negedge clk);
        check({tag, "_busy"}, 64'(bus.busy), 64'd0);
        check({tag, "_left"}, 64'(q0.size() + q1.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int         tr;
        int         td0;
        int         cnt;
        logic [5:0] hpat;
        logic [5:0] v0, v1, e0, e1;
        logic       p;

        bus.in_data = '0; bus.in_first = 1'b0; bus.in_last = 1'b0;
        bus.in_valid = 1'b0; bus.hold = 1'b0;

        // Reset state
        #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_tile_done", 64'(bus.tile_done), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("release_in_ready_early", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("release_in_ready", 64'(bus.in_ready), 64'd1);

        // Single vector timing
        push_vec(16'h0100, 16'h0200, 1'b1, 1'b1, tr);
        check("t2_tries", 64'(tr), 64'd1);
        check("t2_e0_valid", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("t2_e1_valid", 64'(bus.out_valid), 64'b01);
        check("t2_e1_lane0", 64'(bus.out_input[DW-1:0]), 64'h0100);
        check("t2_e1_switch", 64'(bus.out_switch), 64'b01);
        check("t2_e1_td", 64'(bus.tile_done), 64'd0);
        @(negedge clk);
        check("t2_e2_valid", 64'(bus.out_valid), 64'b10);
        check("t2_e2_lane1", 64'(bus.out_input[2*DW-1:DW]), 64'h0200);
        check("t2_e2_switch", 64'(bus.out_switch), 64'b10);
        check("t2_e2_td", 64'(bus.tile_done), 64'd1);
        @(negedge clk);
        check("t2_e3_valid", 64'(bus.out_valid), 64'd0);
        check("t2_e3_busy", 64'(bus.busy), 64'd0);

        // Streaming 4 vectors back to back
        td0 = td_seen;
        for (int i = 1; i <= 4; i++) begin
            push_vec(DW'(i), DW'(i), i == 1, i == 4, tr);
            check("t3_ready", 64'(tr), 64'd1);
        end
        drain("t3");
        check("t3_td_count", 64'(td_seen - td0), 64'd1);

        // Full FIFO under hold, fifth vector stalls until a pop
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_vec(DW'(16'h10 + i), DW'(16'h20 + i), i == 1, 1'b0, tr);
            check("t4_accept", 64'(tr), 64'd1);
        end
        bus.in_valid = 1'b1;
        #1 check("t4_full_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("t4_still_full", 64'(bus.in_ready), 64'd0);
        bus.hold = 1'b0;
        push_vec(16'h15, 16'h25, 1'b0, 1'b1, tr);
        check("t4_fifth_tries", 64'(tr), 64'd2);
        drain("t4");

        // Single-cycle hold between vectors 2 and 3 inserts one bubble per row
        bus.hold = 1'b1;
        for (int i = 1; i <= 4; i++) push_vec(DW'(16'h30 + i), DW'(16'h40 + i), i == 1, i == 4, tr);
        hpat = 6'b000100;
        cnt = 4;
        for (int k = 0; k < 6; k++) begin
            p = (cnt > 0) && !hpat[k];
            if (p) cnt--;
            e0[k] = p;
            e1[k] = (k == 0) ? 1'b0 : e0[k-1];
        end
        for (int k = 0; k < 6; k++) begin
            bus.hold = hpat[k];
            @(negedge clk);
            v0[k] = bus.out_valid[0];
            v1[k] = bus.out_valid[1];
        end
        check("t5_row0_pattern", 64'(v0), 64'(e0));
        check("t5_row1_pattern", 64'(v1), 64'(e1));
        bus.hold = 1'b0;
        drain("t5");

        // Wrap: continuous push with random hold
        fork
            begin
                for (int i = 0; i < 12; i++)
                    push_vec(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), tr);
            end
            begin
                repeat (40) begin
                    bus.hold = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.hold = 1'b0;
            end
        join
        bus.hold = 1'b0;
        drain("t6");

        // Reset mid-stream discards queued and in-flight vectors
        push_vec(16'hAAAA, 16'hBBBB, 1'b1, 1'b0, tr);
        push_vec(16'hCCCC, 16'hDDDD, 1'b0, 1'b1, tr);
        #2 rst = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("t1_valid", 64'(bus.out_valid), 64'd0);
        check("t1_input", 64'(bus.out_input), 64'd0);
        check("t1_busy", 64'(bus.busy), 64'd0);
        check("t1_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("t1_ready_early", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("t1_ready", 64'(bus.in_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("t1_no_stale", 64'(bus.busy), 64'd0);
        push_vec(16'h0777, 16'h0888, 1'b1, 1'b1, tr);
        drain("t1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
